// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle MULT/DIV unit: FSM encoding and
// iteration counter sizing.
package muldiv_pkg;

  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem_i, dividend_bit_i};
  assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
  // A clear borrow bit means the divisor fit into the shifted remainder.
  assign q_bit_o = ~trial[WIDTH+1];
  assign rem_o   = q_bit_o ? trial[WIDTH:0] : shifted;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT (radix-2 Booth) / DIV (restoring) unit producing HI/LO,
// one iteration per clock, with busy/done handshake for the controller stall logic.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = muldiv_pkg::ITERS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  import muldiv_pkg::*;

  logic [1:0]       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  // acc: Booth accumulator (WIDTH+1 so -2^31 * -2^31 cannot overflow) / DIV remainder
  logic [WIDTH:0]   acc_q, acc_d;
  // q: Booth multiplier / DIV dividend magnitude shifting into quotient
  logic [WIDTH-1:0] q_q, q_d;
  // m: multiplicand / divisor magnitude
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_mag;
  logic             last_iter;

  assign m_ext     = {m_q[WIDTH-1], m_q};
  assign last_iter = (cnt_q == cnt_t'(ITERS - 1));

  always_comb begin
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
  end

  assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i          (acc_q[WIDTH-1:0]),
    .dividend_bit_i (q_q[WIDTH-1]),
    .divisor_i      (m_q),
    .rem_o          (rem_next),
    .q_bit_o        (q_bit)
  );

  assign quo_next = {q_q[WIDTH-2:0], q_bit};
  assign rem_mag  = rem_next[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          state_d = ST_MULT;
          cnt_d   = '0;
          dz_d    = 1'b0;
          acc_d   = '0;
          q_d     = a;
          qm1_d   = 1'b0;
          m_d     = b;
        end else if (start_div) begin
          state_d   = ST_DIV;
          cnt_d     = '0;
          dz_d      = 1'b0;
          acc_d     = '0;
          q_d       = a[WIDTH-1] ? -a : a;
          m_d       = b[WIDTH-1] ? -b : b;
          neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
        end
      end
      ST_MULT: begin
        acc_d = booth_acc;
        q_d   = booth_q;
        qm1_d = q_q[0];
        cnt_d = cnt_q + cnt_t'(1);
        if (last_iter) begin
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_q;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DIV: begin
        if (m_q == '0) begin
          // Divide by zero finishes immediately and leaves HI/LO untouched.
          state_d = ST_DONE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end else begin
          acc_d = rem_next;
          q_d   = quo_next;
          cnt_d = cnt_q + cnt_t'(1);
          if (last_iter) begin
            lo_d    = neg_quo_q ? -quo_next : quo_next;
            hi_d    = neg_rem_q ? -rem_mag : rem_mag;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a_in),
    .b          (b_in),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  // Reference: full-precision signed arithmetic, truncating division.
  task automatic model_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          output bit mdz, output int mlat);
    longint sa, sb, p, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mdz = 1'b0;
    mlat = 32;
    if (!is_div) begin
      p = sa * sb;
      mhi = p[63:32];
      mlo = p[31:0];
    end else if (b == 32'd0) begin
      mdz = 1'b1;
      mlat = 1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      mhi = rr[31:0];
      mlo = qq[31:0];
    end
  endtask

  task automatic run_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                        output bit rdz, output bit rbusy, output int ndone, output bit dz_start);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    dz_start = div_zero;
    lat = -1;
    ndone = 0;
    rhi = hi;
    rlo = lo;
    rdz = 1'b0;
    rbusy = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          rhi = hi;
          rlo = lo;
          rdz = div_zero;
          rbusy = busy;
        end
      end
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want %h", hi, 32'd0); end
    n_checks++;
    if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want %h", lo, 32'd0); end
    n_checks++;
    if ({busy, done, div_zero} !== 3'b000)
      begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero}); end
    @(negedge clk);
    start_mult = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_mult = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    $display("reset: hi=%h lo=%h busy=%b done=%b div_zero=%b", hi, lo, busy, done, div_zero);
  endtask

  task automatic test_directed(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ehi, input logic [31:0] elo);
    int lat, nd, mlat;
    logic [31:0] rhi, rlo;
    bit rdz, rbusy, dzs, mdz;
    model_op(is_div, a, b, mdz, mlat);
    run_op(!is_div, is_div, a, b, lat, rhi, rlo, rdz, rbusy, nd, dzs);
    $display("%s a=%h b=%h -> hi=%h lo=%h lat=%0d", is_div ? "div " : "mult", a, b, rhi, rlo, lat);
    n_checks++;
    if (lat !== 32) begin n_fail++; $display("FAIL dir_latency: got %0d want 32", lat); end
    n_checks++;
    if (rhi !== ehi) begin n_fail++; $display("FAIL dir_hi: got %h want %h", rhi, ehi); end
    n_checks++;
    if (rlo !== elo) begin n_fail++; $display("FAIL dir_lo: got %h want %h", rlo, elo); end
    n_checks++;
    if (rbusy !== 1'b1 || nd !== 1)
      begin n_fail++; $display("FAIL dir_busy_done: busy=%b ndone=%0d want 1/1", rbusy, nd); end
  endtask

  task automatic test_mult();
    test_directed(1'b0, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1);
    test_directed(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    test_directed(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
  endtask

  task automatic test_div();
    test_directed(1'b1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    test_directed(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_directed(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
  endtask

  task automatic test_div_zero();
    int lat, nd, mlat;
    logic [31:0] rhi, rlo, phi, plo;
    bit rdz, rbusy, dzs, mdz;
    phi = mhi;
    plo = mlo;
    model_op(1'b1, 32'd5, 32'd0, mdz, mlat);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, lat, rhi, rlo, rdz, rbusy, nd, dzs);
    $display("div  a=%h b=%h -> hi=%h lo=%h lat=%0d div_zero=%b", 32'd5, 32'd0, rhi, rlo, lat, rdz);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
    n_checks++;
    if (rdz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", rdz); end
    n_checks++;
    if (rhi !== phi || rlo !== plo)
      begin n_fail++; $display("FAIL dz_hold: got %h/%h want %h/%h", rhi, rlo, phi, plo); end
    model_op(1'b0, 32'd6, 32'd7, mdz, mlat);
    run_op(1'b1, 1'b0, 32'd6, 32'd7, lat, rhi, rlo, rdz, rbusy, nd, dzs);
    $display("mult a=%h b=%h -> hi=%h lo=%h lat=%0d", 32'd6, 32'd7, rhi, rlo, lat);
    n_checks++;
    if (dzs !== 1'b0 || rdz !== 1'b0)
      begin n_fail++; $display("FAIL dz_clear: start=%b done=%b want 0/0", dzs, rdz); end
    n_checks++;
    if (rlo !== 32'd42 || rhi !== 32'd0)
      begin n_fail++; $display("FAIL dz_next_result: got %h/%h want 0/2a", rhi, rlo); end
  endtask

  task automatic test_back_to_back();
    int lat, nd, mlat, extra;
    logic [31:0] rhi, rlo;
    bit rdz, rbusy, dzs, mdz;
    model_op(1'b0, 32'd12345, 32'hFFFFFFF9, mdz, mlat);
    @(negedge clk);
    start_mult = 1'b1;
    a_in = 32'd12345;
    b_in = 32'hFFFFFFF9;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    lat = -1;
    nd = 0;
    rhi = hi;
    rlo = lo;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start_div = 1'b1;
        a_in = 32'd100;
        b_in = 32'd3;
      end
      @(posedge clk);
      #1;
      start_div = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = i; rhi = hi; rlo = lo; end
      end
      if (!busy) break;
    end
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (busy || done) extra++;
    end
    $display("mult a=%h b=%h (div pulsed mid-op) -> hi=%h lo=%h lat=%0d", 32'd12345, 32'hFFFFFFF9, rhi, rlo, lat);
    n_checks++;
    if (lat !== 32 || nd !== 1)
      begin n_fail++; $display("FAIL busy_ignore_timing: lat=%0d ndone=%0d want 32/1", lat, nd); end
    n_checks++;
    if (rhi !== mhi || rlo !== mlo)
      begin n_fail++; $display("FAIL busy_ignore_result: got %h/%h want %h/%h", rhi, rlo, mhi, mlo); end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL busy_no_queue: got %0d active cycles want 0", extra); end

    model_op(1'b0, 32'hFFFF0003, 32'h00020001, mdz, mlat);
    run_op(1'b1, 1'b1, 32'hFFFF0003, 32'h00020001, lat, rhi, rlo, rdz, rbusy, nd, dzs);
    $display("both a=%h b=%h -> hi=%h lo=%h lat=%0d", 32'hFFFF0003, 32'h00020001, rhi, rlo, lat);
    n_checks++;
    if (lat !== 32 || nd !== 1)
      begin n_fail++; $display("FAIL both_start_timing: lat=%0d ndone=%0d want 32/1", lat, nd); end
    n_checks++;
    if (rhi !== mhi || rlo !== mlo)
      begin n_fail++; $display("FAIL both_start_result: got %h/%h want %h/%h", rhi, rlo, mhi, mlo); end
  endtask

  task automatic test_reset_mid_op();
    int lat, nd, mlat, stray;
    logic [31:0] rhi, rlo;
    bit rdz, rbusy, dzs, mdz;
    @(negedge clk);
    start_div = 1'b1;
    a_in = 32'd1000;
    b_in = 32'd7;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    mhi = '0;
    mlo = '0;
    #1;
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL midreset_state: hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    $display("reset mid-div: stray active cycles=%0d", stray);
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d want 0", stray); end
    model_op(1'b0, 32'hDEADBEEF, 32'h01234567, mdz, mlat);
    run_op(1'b1, 1'b0, 32'hDEADBEEF, 32'h01234567, lat, rhi, rlo, rdz, rbusy, nd, dzs);
    $display("mult a=%h b=%h -> hi=%h lo=%h lat=%0d", 32'hDEADBEEF, 32'h01234567, rhi, rlo, lat);
    n_checks++;
    if (lat !== 32 || rhi !== mhi || rlo !== mlo)
      begin n_fail++; $display("FAIL midreset_recover: lat=%0d %h/%h want 32 %h/%h", lat, rhi, rlo, mhi, mlo); end
  endtask

  task automatic test_random(input int n_ops);
    logic [31:0] corners [6];
    logic [31:0] ra, rb, rhi, rlo;
    int lat, nd, mlat;
    bit is_div, rdz, rbusy, dzs, mdz;
    corners = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
    for (int k = 0; k < n_ops; k++) begin
      is_div = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      model_op(is_div, ra, rb, mdz, mlat);
      run_op(!is_div, is_div, ra, rb, lat, rhi, rlo, rdz, rbusy, nd, dzs);
      $display("rand %0d %s a=%h b=%h -> hi=%h lo=%h lat=%0d dz=%b", k, is_div ? "div " : "mult",
               ra, rb, rhi, rlo, lat, rdz);
      n_checks++;
      if (lat !== mlat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, mlat); end
      n_checks++;
      if (rhi !== mhi) begin n_fail++; $display("FAIL rand_hi[%0d]: got %h want %h", k, rhi, mhi); end
      n_checks++;
      if (rlo !== mlo) begin n_fail++; $display("FAIL rand_lo[%0d]: got %h want %h", k, rlo, mlo); end
      n_checks++;
      if (rdz !== mdz) begin n_fail++; $display("FAIL rand_div_zero[%0d]: got %b want %b", k, rdz, mdz); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_random(1500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
